// File: rtl/wshb_ram_slave.sv
// wshb_ram_slave: Wishbone 16-bit RAM slave with programmable wait states and incrementing bursts
// Ports:
//   CLK, NRST              - clock (rising edge), asynchronous active-low reset
//   wb_cyc, wb_stb, wb_we  - cycle, strobe, write enable from master
//   wb_adr                 - byte address, bit 0 ignored, upper bits out of range -> wb_err
//   wb_sel, wb_dat_ms      - byte enables and write data
//   wb_cti                 - cycle type: 000 classic, 010 incrementing burst, 111 end of burst
//   wb_dat_sm, wb_ack, wb_err - registered read data and terminations
module wshb_ram_slave #(
    parameter int ADDR_W      = 10,
    parameter int WAIT_STATES = 0
) (
    input  logic        CLK,
    input  logic        NRST,
    input  logic        wb_cyc,
    input  logic        wb_stb,
    input  logic        wb_we,
    input  logic [31:0] wb_adr,
    input  logic [1:0]  wb_sel,
    input  logic [15:0] wb_dat_ms,
    input  logic [2:0]  wb_cti,
    output logic [15:0] wb_dat_sm,
    output logic        wb_ack,
    output logic        wb_err
);
    typedef enum logic [1:0] {S_IDLE, S_WAIT, S_ACK, S_BURST} state_t;

    state_t            state_q, state_d;
    logic [3:0]        cnt_q, cnt_d;
    logic [ADDR_W-1:0] idx_q, idx_d;
    logic              oor_q, oor_d;
    logic              ack_q, ack_d;
    logic              err_q, err_d;
    logic [15:0]       dat_q, dat_d;
    logic [15:0]       mem [2**ADDR_W];
    logic              req;
    logic              unused_adr0;

    assign req         = wb_cyc & wb_stb;
    assign unused_adr0 = wb_adr[0];
    assign wb_ack      = ack_q;
    assign wb_err      = err_q;
    assign wb_dat_sm   = dat_q;

    always_ff @(posedge CLK or negedge NRST) begin
        if (!NRST) begin
            state_q <= S_IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            oor_q   <= 1'b0;
            ack_q   <= 1'b0;
            err_q   <= 1'b0;
            dat_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            oor_q   <= oor_d;
            ack_q   <= ack_d;
            err_q   <= err_d;
            dat_q   <= dat_d;
        end
    end

    // WAIT leaves on the edge where the counter would hit zero, so the
    // termination lands exactly WAIT_STATES cycles after the zero-wait case.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        idx_d   = idx_q;
        oor_d   = oor_q;
        case (state_q)
            S_IDLE: if (req) begin
                idx_d   = wb_adr[ADDR_W:1];
                oor_d   = |wb_adr[31:ADDR_W+1];
                cnt_d   = 4'(WAIT_STATES);
                state_d = WAIT_STATES > 0 ? S_WAIT : S_ACK;
            end
            S_WAIT: begin
                cnt_d   = wb_cyc && cnt_q > 4'd1 ? cnt_q - 4'd1 : 4'd0;
                state_d = !wb_cyc ? S_IDLE : cnt_q <= 4'd1 ? S_ACK : S_WAIT;
            end
            S_ACK:   state_d = req && wb_cti == 3'b010 && !oor_q ? S_BURST : S_IDLE;
            S_BURST: if (req && wb_cti != 3'b111) idx_d = idx_q + ADDR_W'(1);
                     else state_d = S_IDLE;
        endcase
    end

    // In BURST the bus still shows the beat being acked; cti=111 there means
    // the current beat was the last one, so no further ack is issued.
    always_comb begin
        ack_d = (state_q == S_ACK && req && !oor_q) || (state_q == S_BURST && req && wb_cti != 3'b111);
        err_d = state_q == S_ACK && req && oor_q;
        dat_d = ack_d ? mem[idx_d] : '0;
    end

    // Write commits at the edge closing the ack cycle; reset clears ack_q so an
    // interrupted transfer never writes.
    always_ff @(posedge CLK) begin
        if (ack_q && req && wb_we) begin
            if (wb_sel[0]) mem[idx_q][7:0]  <= wb_dat_ms[7:0];
            if (wb_sel[1]) mem[idx_q][15:8] <= wb_dat_ms[15:8];
        end
    end
endmodule

// File: tb/tb_wshb_ram_slave.sv
// tb_wshb_ram_slave: directed checks of wshb_ram_slave with zero and three wait states
module tb_wshb_ram_slave;
    logic        clk = 1'b0;
    logic        nrst = 1'b0;
    logic        cyc = 1'b0, stb = 1'b0, we = 1'b0;
    logic [31:0] adr = '0;
    logic [1:0]  sel = '0;
    logic [15:0] dms = '0;
    logic [2:0]  cti = '0;
    logic [15:0] dat0, dat3;
    logic        ack0, err0, ack3, err3;
    int          checks = 0, failures = 0;

    always #5 clk = ~clk;

    wshb_ram_slave #(.ADDR_W(10), .WAIT_STATES(0)) u0 (
        .CLK(clk), .NRST(nrst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
        .wb_sel(sel), .wb_dat_ms(dms), .wb_cti(cti), .wb_dat_sm(dat0), .wb_ack(ack0), .wb_err(err0)
    );

    wshb_ram_slave #(.ADDR_W(10), .WAIT_STATES(3)) u3 (
        .CLK(clk), .NRST(nrst), .wb_cyc(cyc), .wb_stb(stb), .wb_we(we), .wb_adr(adr),
        .wb_sel(sel), .wb_dat_ms(dms), .wb_cti(cti), .wb_dat_sm(dat3), .wb_ack(ack3), .wb_err(err3)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // Classic single transfer on instance w (0 or 3); lat counts edges after the sampling edge.
    task automatic xfer(input int w, input logic wr, input logic [31:0] a, input logic [1:0] s,
                        input logic [15:0] d, output logic [15:0] rd, output logic ak,
                        output logic er, output int lat);
        logic done;
        cyc = 1'b1; stb = 1'b1; we = wr; adr = a; sel = s; dms = d; cti = 3'b000;
        lat = -1; done = 1'b0; rd = '0; ak = 1'b0; er = 1'b0;
        for (int i = 0; i < 20 && !done; i++) begin
            @(posedge clk);
            lat++;
            @(negedge clk);
            ak = w == 3 ? ack3 : ack0;
            er = w == 3 ? err3 : err0;
            rd = w == 3 ? dat3 : dat0;
            done = ak | er;
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        if (!done) lat = 99;
        repeat (2) @(posedge clk);
        #1;
    endtask

    logic [15:0] rd;
    logic        ak, er;
    int          lat, n;
    logic [5:0]  seq;
    logic [15:0] bexp [4];

    initial begin
        bexp = '{16'hA001, 16'hA002, 16'hA003, 16'hA004};
        repeat (2) @(posedge clk);
        #1;
        chk("rst_u0", {14'd0, ack0, err0, dat0}, 32'd0);
        chk("rst_u3", {14'd0, ack3, err3, dat3}, 32'd0);
        nrst = 1'b1;
        @(posedge clk); #1;

        xfer(0, 1'b1, 32'h10, 2'b11, 16'hBEEF, rd, ak, er, lat);
        chk("wr10_ack", {31'd0, ak}, 32'd1);
        chk("wr10_lat", lat, 32'd1);
        xfer(0, 1'b0, 32'h10, 2'b00, 16'h0, rd, ak, er, lat);
        chk("rd10_lat", lat, 32'd1);
        chk("rd10_dat", {16'd0, rd}, 32'hBEEF);

        xfer(0, 1'b1, 32'h20, 2'b01, 16'h1234, rd, ak, er, lat);
        xfer(0, 1'b1, 32'h20, 2'b10, 16'hAB00, rd, ak, er, lat);
        xfer(0, 1'b0, 32'h20, 2'b00, 16'h0, rd, ak, er, lat);
        chk("rd20_dat", {16'd0, rd}, 32'hAB34);

        // held classic request: acks must alternate, never back to back
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h10; cti = 3'b000; seq = '0;
        @(posedge clk);
        repeat (6) begin
            @(negedge clk);
            seq = {seq[4:0], ack0};
        end
        chk("alt_ack", {26'd0, seq}, 32'h15);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0;
        repeat (2) @(posedge clk);
        #1;

        xfer(0, 1'b1, 32'h7FC, 2'b11, 16'hA001, rd, ak, er, lat);
        xfer(0, 1'b1, 32'h7FE, 2'b11, 16'hA002, rd, ak, er, lat);
        xfer(0, 1'b1, 32'h000, 2'b11, 16'hA003, rd, ak, er, lat);
        xfer(0, 1'b1, 32'h002, 2'b11, 16'hA004, rd, ak, er, lat);

        // 4-beat wrapping burst read; master advances after each edge that closes an ack
        cyc = 1'b1; stb = 1'b1; we = 1'b0; adr = 32'h7FC; cti = 3'b010;
        @(posedge clk);
        @(posedge clk);
        @(negedge clk);
        chk("bst_ack0", {31'd0, ack0}, 32'd1);
        chk("bst_dat0", {16'd0, dat0}, {16'd0, bexp[0]});
        for (int k = 1; k < 4; k++) begin
            @(posedge clk); #1;
            adr = (32'h7FC + 32'(2 * k)) & 32'h7FF;
            cti = k == 3 ? 3'b111 : 3'b010;
            @(negedge clk);
            chk($sformatf("bst_ack%0d", k), {31'd0, ack0}, 32'd1);
            chk($sformatf("bst_dat%0d", k), {16'd0, dat0}, {16'd0, bexp[k]});
        end
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; cti = 3'b000;
        @(negedge clk);
        chk("bst_end_ack", {31'd0, ack0}, 32'd0);
        chk("bst_end_dat", {16'd0, dat0}, 32'd0);
        repeat (2) @(posedge clk);
        #1;

        xfer(0, 1'b1, 32'h800, 2'b11, 16'h5555, rd, ak, er, lat);
        chk("oor_wr_err", {31'd0, er}, 32'd1);
        chk("oor_wr_ack", {31'd0, ak}, 32'd0);
        xfer(0, 1'b0, 32'h800, 2'b11, 16'h0, rd, ak, er, lat);
        chk("oor_rd_err", {31'd0, er}, 32'd1);
        chk("oor_rd_dat", {16'd0, rd}, 32'd0);
        xfer(0, 1'b0, 32'h000, 2'b11, 16'h0, rd, ak, er, lat);
        chk("oor_nowr", {16'd0, rd}, 32'hA003);

        xfer(3, 1'b1, 32'h40, 2'b11, 16'h1111, rd, ak, er, lat);
        chk("ws3_wr_ack", {31'd0, ak}, 32'd1);
        chk("ws3_wr_lat", lat, 32'd4);
        xfer(3, 1'b0, 32'h40, 2'b11, 16'h0, rd, ak, er, lat);
        chk("ws3_rd_lat", lat, 32'd4);
        chk("ws3_rd_dat", {16'd0, rd}, 32'h1111);

        // drop wb_cyc while waiting: no termination, no write
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 2'b11; dms = 16'h2222;
        @(posedge clk);
        @(posedge clk); #1;
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        n = 0;
        repeat (6) begin
            @(negedge clk);
            n += int'(ack3 | err3);
        end
        chk("drop_noack", n, 32'd0);
        @(posedge clk); #1;
        xfer(3, 1'b0, 32'h40, 2'b11, 16'h0, rd, ak, er, lat);
        chk("drop_nowr", {16'd0, rd}, 32'h1111);

        // reset mid-write: u3 is waiting, u0 is mid-ack
        cyc = 1'b1; stb = 1'b1; we = 1'b1; adr = 32'h40; sel = 2'b11; dms = 16'h3333;
        @(posedge clk);
        @(posedge clk); #1;
        chk("pre_rst_ack0", {31'd0, ack0}, 32'd1);
        nrst = 1'b0;
        #1;
        chk("async_rst_u0", {14'd0, ack0, err0, dat0}, 32'd0);
        chk("async_rst_u3", {14'd0, ack3, err3, dat3}, 32'd0);
        cyc = 1'b0; stb = 1'b0; we = 1'b0;
        @(negedge clk);
        nrst = 1'b1;
        @(posedge clk); #1;
        xfer(3, 1'b0, 32'h40, 2'b11, 16'h0, rd, ak, er, lat);
        chk("post_rst_lat", lat, 32'd4);
        chk("post_rst_u3", {16'd0, rd}, 32'h1111);
        xfer(0, 1'b0, 32'h40, 2'b11, 16'h0, rd, ak, er, lat);
        chk("post_rst_u0", {16'd0, rd}, 32'h1111);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/wshb_ram_slave.md
WSHB_RAM_SLAVE -- requirements
Module: wshb_ram_slave

Interface
REQ-001 SHALL have parameter ADDR_W, default 10, giving memory depth as 2**ADDR_W 16-bit words.
REQ-002 SHALL have parameter WAIT_STATES, default 0, giving extra cycles inserted before the first ack of a cycle, range 0..15.
REQ-003 SHALL have port CLK, input, 1 bit: sole clock, rising edge.
REQ-004 SHALL have port NRST, input, 1 bit: asynchronous, active-low reset.
REQ-005 SHALL have port wb_cyc, input, 1 bit: bus cycle in progress.
REQ-006 SHALL have port wb_stb, input, 1 bit: transfer strobe.
REQ-007 SHALL have port wb_we, input, 1 bit: 1 = write, 0 = read.
REQ-008 SHALL have port wb_adr, input, 32 bits: byte address; bit 0 ignored.
REQ-009 SHALL have port wb_sel, input, 2 bits: byte enables; bit 1 = dat[15:8].
REQ-010 SHALL have port wb_dat_ms, input, 16 bits: write data.
REQ-011 SHALL have port wb_cti, input, 3 bits: 3'b000 classic, 3'b010 incrementing burst, 3'b111 end of burst.
REQ-012 SHALL have port wb_dat_sm, output, 16 bits: read data, valid while wb_ack=1.
REQ-013 SHALL have port wb_ack, output, 1 bit: normal termination.
REQ-014 SHALL have port wb_err, output, 1 bit: error termination.

Function
REQ-015 SHALL hold a 2**ADDR_W x 16 memory; word index = wb_adr[ADDR_W:1].
REQ-016 SHALL treat any nonzero bit in wb_adr[31:ADDR_W+1] as out of range.
REQ-017 SHALL implement states IDLE, WAIT, ACK, BURST.
REQ-018 IDLE: on wb_cyc&wb_stb sampled, SHALL go to WAIT with counter = WAIT_STATES if WAIT_STATES>0, else to ACK.
REQ-019 WAIT: SHALL decrement the counter each cycle and go to ACK on the cycle after the counter reaches 0.
REQ-020 In state ACK, wb_ack SHALL be 1 for in-range requests; wb_err SHALL be 1 instead for out-of-range requests. Both are registered outputs and are never high together.
REQ-021 Latency: for a request first sampled at edge N, the termination SHALL be visible after edge N+1+WAIT_STATES.
REQ-022 Writes SHALL update only the bytes enabled by wb_sel, at the edge that ends the ack cycle. Out-of-range writes and writes with wb_sel=0 SHALL leave the memory unchanged.
REQ-023 Reads SHALL present mem[index] on wb_dat_sm during ack. wb_dat_sm SHALL be 0 when neither ack nor err is high.
REQ-024 From ACK: if wb_cyc&wb_stb&(wb_cti==3'b010) and the request is in range, SHALL go to BURST; otherwise SHALL go to IDLE.
REQ-025 BURST: SHALL assert wb_ack every cycle with the word index incremented by 1 per beat, wrapping from 2**ADDR_W-1 to 0. No wait states SHALL be inserted within a burst.
REQ-026 BURST: SHALL return to IDLE after the beat in which wb_cti==3'b111, or when wb_stb=0 or wb_cyc=0 is sampled. If wb_stb=0 or wb_cyc=0, no ack SHALL be given for that cycle.
REQ-027 In classic mode, wb_ack SHALL never be high on two consecutive cycles. A request held after an ack SHALL be treated as a new request starting from IDLE.
REQ-028 If wb_cyc drops in WAIT or ACK, the block SHALL return to IDLE with no termination and no memory write.
REQ-029 If wb_stb=1 with wb_cyc=0, the block SHALL ignore the request.

Reset
REQ-030 NRST=0 SHALL immediately force state IDLE, wb_ack=0, wb_err=0, wb_dat_sm=0 and the wait counter to 0.
REQ-031 Memory contents SHALL NOT be reset. A transfer interrupted by reset SHALL NOT write memory.
REQ-032 After NRST is released, the first request sampled at a rising CLK edge SHALL be serviced normally.

Verification
REQ-033 WAIT_STATES=0: write 0xBEEF at 0x10 with sel=11, then read 0x10 -> ack 1 cycle after each request is sampled; read data 0xBEEF.
REQ-034 Write 0x1234 at 0x20 with sel=01, then write 0xAB00 at 0x20 with sel=10, then read 0x20 -> data 0xAB34.
REQ-035 WAIT_STATES=3: read -> ack on the 4th cycle after sampling; drop wb_cyc on cycle 2 -> no ack and no write.
REQ-036 Burst read of 4 beats from word 2**ADDR_W-2 with cti 010,010,010,111 -> 4 consecutive acks; data words at indices 2**ADDR_W-2, 2**ADDR_W-1, 0, 1.
REQ-037 Access at wb_adr=2**(ADDR_W+1) -> wb_err=1, wb_ack=0; that address has no write effect on memory.
REQ-038 Assert NRST=0 during WAIT of a write -> all outputs 0 immediately; a later read of that address returns the old data.
